// File: rtl/jtag_tap_top.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_top
// Purpose  : IEEE 1149.1 TAP controller with IDCODE, BYPASS and an optional
//            32-bit USER data register. TCK/TMS/TDI are oversampled into the
//            clk domain; TCK edges are detected, so the block is single-clock.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active-high
//            test_mode  - 1 holds the TAP in Test-Logic-Reset, TDO forced 0
//            tap_tck    - JTAG TCK, asynchronous to clk
//            tap_tms    - JTAG TMS
//            tap_tdi    - JTAG TDI
//            tap_tdo    - JTAG TDO, always driven
//            user_reg   - USER register contents
// Config   : JTAG_USER_REG_EN - when defined, the USER register (IR 5'h10)
//            exists; otherwise 5'h10 decodes as BYPASS and user_reg is 0.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_top #(
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int          IR_WIDTH    = 5,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        test_mode,
  input  logic        tap_tck,
  input  logic        tap_tms,
  input  logic        tap_tdi,
  output logic        tap_tdo,
  output logic [31:0] user_reg
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(5'h01);
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(5'h10);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(5'h01);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  tap_state_t state;
  tap_state_t next_state;

  logic [SYNC_STAGES-1:0] tck_sync;
  logic [SYNC_STAGES-1:0] tms_sync;
  logic [SYNC_STAGES-1:0] tdi_sync;
  logic                   tck_prev;

  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         dr_shift;   // shared by IDCODE and USER
  logic                bypass;
  logic [31:0]         user_cur;

  // TMS/TDI are read from the same stage as TCK so all three stay aligned.
  logic tck_s, tms_s, tdi_s;
  logic tck_rise, tck_fall;
  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;

`ifdef JTAG_USER_REG_EN
  localparam bit USER_EN = 1'b1;
  logic [31:0] user_q;
  assign user_cur = user_q;
`else
  localparam bit USER_EN = 1'b0;
  assign user_cur = 32'h0;
`endif

  assign user_reg = user_cur;

  logic sel_idcode, sel_user;
  always_comb begin
    sel_idcode = (ir == IR_IDCODE);
    sel_user   = USER_EN && (ir == IR_USER);
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:    next_state = tms_s ? TLR    : RTI;
      RTI:    next_state = tms_s ? SEL_DR : RTI;
      SEL_DR: next_state = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms_s ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms_s ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms_s ? UPD_DR : PAU_DR;
      PAU_DR: next_state = tms_s ? EX2_DR : PAU_DR;
      EX2_DR: next_state = tms_s ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms_s ? SEL_DR : RTI;
      SEL_IR: next_state = tms_s ? TLR    : CAP_IR;
      CAP_IR: next_state = tms_s ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms_s ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms_s ? UPD_IR : PAU_IR;
      PAU_IR: next_state = tms_s ? EX2_IR : PAU_IR;
      EX2_IR: next_state = tms_s ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms_s ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
      state    <= TLR;
      ir       <= IR_IDCODE;
      ir_shift <= '0;
      dr_shift <= '0;
      bypass   <= 1'b0;
      tap_tdo  <= 1'b0;
`ifdef JTAG_USER_REG_EN
      user_q   <= 32'h0;
`endif
    end else begin
      tck_sync[0] <= tap_tck;
      tms_sync[0] <= tap_tms;
      tdi_sync[0] <= tap_tdi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        tck_sync[i] <= tck_sync[i-1];
        tms_sync[i] <= tms_sync[i-1];
        tdi_sync[i] <= tdi_sync[i-1];
      end
      // Edge history keeps running in test_mode so release cannot fake an edge.
      tck_prev <= tck_s;

      if (test_mode) begin
        state   <= TLR;
        ir      <= IR_IDCODE;
        tap_tdo <= 1'b0;
      end else begin
        if (state == TLR)
          ir <= IR_IDCODE;

        // Capture and shift act on the rise that leaves the current state.
        if (tck_rise) begin
          state <= next_state;
          case (state)
            CAP_IR: ir_shift <= IR_CAPTURE;
            SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
            CAP_DR: begin
              bypass <= 1'b0;
              if (sel_idcode)    dr_shift <= IDCODE_VAL;
              else if (sel_user) dr_shift <= user_cur;
            end
            SH_DR: begin
              if (sel_idcode || sel_user) dr_shift <= {tdi_s, dr_shift[31:1]};
              else                        bypass   <= tdi_s;
            end
            default: ;
          endcase
        end

        // TDO and the update stages act on the falling edge, as on a real TAP.
        if (tck_fall) begin
          case (state)
            SH_IR:   tap_tdo <= ir_shift[0];
            SH_DR:   tap_tdo <= (sel_idcode || sel_user) ? dr_shift[0] : bypass;
            default: tap_tdo <= 1'b0;
          endcase
          if (state == UPD_IR)
            ir <= ir_shift;
`ifdef JTAG_USER_REG_EN
          if (state == UPD_DR && sel_user)
            user_q <= dr_shift;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_top
// Purpose  : Self-checking bench for jtag_tap_top. Drives TCK/TMS/TDI like a
//            JTAG host and compares scan results with a register-level model
//            (current instruction, USER contents).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_top;

  localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
`ifdef JTAG_USER_REG_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_mode = 1'b0;
  logic        tap_tck = 1'b0;
  logic        tap_tms = 1'b0;
  logic        tap_tdi = 1'b0;
  logic        tap_tdo;
  logic [31:0] user_reg;

  int total = 0;
  int bad   = 0;

  logic [4:0]  model_ir;
  logic [31:0] model_user;

  jtag_tap_top #(
    .IDCODE_VAL (IDCODE_VAL),
    .IR_WIDTH   (5),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .test_mode(test_mode),
    .tap_tck  (tap_tck),
    .tap_tms  (tap_tms),
    .tap_tdi  (tap_tdi),
    .tap_tdo  (tap_tdo),
    .user_reg (user_reg)
  );

  always #5 clk = ~clk;

  // One full TCK period; returns TDO as the host sees it before the next rise.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_o);
    @(negedge clk);
    tap_tms = tms;
    tap_tdi = tdi;
    repeat (2) @(negedge clk);
    tap_tck = 1'b1;
    repeat (5) @(negedge clk);
    tap_tck = 1'b0;
    repeat (5) @(negedge clk);
    tdo_o = tap_tdo;
  endtask

  task automatic goto_idle_from_any();
    logic t;
    repeat (5) tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    model_ir = 5'h01;
  endtask

  // Idle -> Shift-IR, shift 5 bits, Update-IR -> Idle.
  task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
    logic t;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      dout[i] = t;
      tck_cycle(i == 4, din[i], t);
    end
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    model_ir = din;
  endtask

  // Idle -> Shift-DR, shift n bits, Update-DR -> Idle.
  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic t;
    dout = '0;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      dout[i] = t;
      tck_cycle(i == n - 1, din[i], t);
    end
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
  endtask

  function automatic logic [31:0] mask_n(input logic [31:0] v, input int n);
    return (n >= 32) ? v : (v & ((32'h1 << n) - 32'h1));
  endfunction

  // Expected scan-out for a DR scan given the current model instruction.
  function automatic logic [31:0] expect_dr(input logic [31:0] din, input int n);
    if (model_ir == 5'h01)
      return mask_n(IDCODE_VAL, n);
    else if (USER_EN && model_ir == 5'h10)
      return mask_n(model_user, n);
    else
      return mask_n(din << 1, n);
  endfunction

  // Scans a DR and checks both the shifted-out data and user_reg afterward.
  task automatic dr_check(input string name, input logic [31:0] din, input int n);
    logic [31:0] got, exp;
    exp = expect_dr(din, n);
    scan_dr(din, n, got);
    if (USER_EN && model_ir == 5'h10 && n == 32) model_user = din;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s tdo: got=%h expected=%h", name, got, exp);
    end
    total++;
    if (user_reg !== model_user) begin
      bad++;
      $display("FAIL %s user_reg: got=%h expected=%h", name, user_reg, model_user);
    end
  endtask

  task automatic ir_check(input string name, input logic [4:0] din);
    logic [4:0] got;
    scan_ir(din, got);
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL %s ir_capture: got=%b expected=00001", name, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_user = 32'h0;
    model_ir   = 5'h01;
    @(negedge clk);
    total++;
    if (tap_tdo !== 1'b0) begin bad++; $display("FAIL reset tdo: got=%b expected=0", tap_tdo); end
    total++;
    if (user_reg !== 32'h0) begin bad++; $display("FAIL reset user_reg: got=%h expected=0", user_reg); end
  endtask

  task automatic test_idcode();
    goto_idle_from_any();
    dr_check("idcode", 32'h0, 32);
  endtask

  task automatic test_bypass();
    ir_check("bypass_ir", 5'h1F);
    dr_check("bypass_4bit", 32'hD, 4);   // TDI 1,0,1,1 -> TDO 0,1,0,1
  endtask

  task automatic test_user();
    ir_check("user_ir", 5'h10);
    dr_check("user_write", 32'hDEAD_BEEF, 32);
    dr_check("user_read", 32'h0, 32);
  endtask

  task automatic test_random();
    logic [4:0]  ir;
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       ir = 5'h01;
        1:       ir = 5'h10;
        2:       ir = 5'h1F;
        default: ir = 5'($urandom());
      endcase
      d = $urandom();
      ir_check("rand_ir", ir);
      dr_check("rand_dr", d, 32);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic t;
    ir_check("rms_ir", 5'h10);
    dr_check("rms_preload", 32'hA5A5_0F0F, 32);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom()), t);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_user = 32'h0;
    model_ir   = 5'h01;
    @(negedge clk);
    total++;
    if (user_reg !== 32'h0) begin bad++; $display("FAIL rms user_reg: got=%h expected=0", user_reg); end
    total++;
    if (tap_tdo !== 1'b0) begin bad++; $display("FAIL rms tdo: got=%b expected=0", tap_tdo); end
    tck_cycle(1'b0, 1'b0, t);  // Test-Logic-Reset -> Run-Test/Idle
    dr_check("rms_idcode", 32'h0, 32);
  endtask

  task automatic test_test_mode();
    logic t;
    ir_check("tm_user_ir", 5'h10);
    dr_check("tm_user_load", 32'h1234_5678, 32);
    ir_check("tm_bypass_ir", 5'h1F);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b1, t);  // bypass now holds 1, shown on TDO
    total++;
    if (t !== 1'b1) begin bad++; $display("FAIL tm_pre tdo: got=%b expected=1", t); end
    @(negedge clk);
    test_mode = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tap_tdo !== 1'b0) begin bad++; $display("FAIL tm_enter tdo: got=%b expected=0", tap_tdo); end
    for (int i = 0; i < 6; i++) begin
      tck_cycle(1'b0, 1'($urandom()), t);
      total++;
      if (t !== 1'b0) begin bad++; $display("FAIL tm_toggle tdo: got=%b expected=0", t); end
    end
    total++;
    if (user_reg !== model_user) begin
      bad++;
      $display("FAIL tm_hold user_reg: got=%h expected=%h", user_reg, model_user);
    end
    @(negedge clk);
    test_mode = 1'b0;
    model_ir  = 5'h01;
    repeat (2) @(negedge clk);
    tck_cycle(1'b0, 1'b0, t);  // Test-Logic-Reset -> Run-Test/Idle
    dr_check("tm_release_idcode", 32'h0, 32);
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_random();
    test_reset_mid_shift();
    test_test_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
